// File: rtl/adder_char_injector.sv
// adder_char_injector: packetised flit generator driving a registered N-bit adder,
// used to characterise adder switching energy. Each 2N-bit flit is split into
// input1 (low half) and input2 (high half).
// Optional feature macro: ADDER_CHAR_TOGGLE_CNT_EN enables the saturating input
// toggle counter; without it toggle_cnt is tied to zero.
module adder_char_injector #(
  parameter int              N        = 17,
  parameter int              PAYLOAD  = 20,
  parameter int              GAP      = 7,
  parameter int              NUM_PKT  = 10,
  parameter int              RUN_LEN  = 20,
  parameter int              ROT_STEP = 4,
  parameter logic [2*N-1:0]  SEED     = 1,
  parameter logic [2*N-1:0]  TAPS     = 34'h204000003,
  parameter int              TCNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic [N-1:0]      input1,
  output logic [N-1:0]      input2,
  output logic              flit_valid,
  output logic [N-1:0]      sum,
  output logic              cout,
  output logic              sum_valid,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pkt_cnt,
  output logic [TCNT_W-1:0] toggle_cnt
);

  localparam int W   = 2 * N;
  localparam int K_W = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1;
  localparam int G_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int RS  = ROT_STEP % W;
  localparam logic [W-1:0] SEED_EFF = (SEED == '0) ? W'(1) : SEED;
  localparam logic [W-1:0] ROT_BASE = {W{1'b1}} >> (W - RUN_LEN);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t         state, state_n;
  logic [K_W-1:0] k;
  logic [G_W-1:0] gap_cnt;
  logic [1:0]     mode_r, mode_sel;
  logic [W-1:0]   flit, flit_first, flit_step, flit_rot;
  logic           load_first, load_next, last_flit, accept;

  assign accept    = (state == S_IDLE) && start;
  assign last_flit = (k == K_W'(PAYLOAD - 1));

  // Rotation by a constant step; a zero step leaves the flit untouched.
  generate
    if (RS == 0) begin : g_rot0
      assign flit_rot = flit;
    end else begin : g_rot
      assign flit_rot = {flit[W-1-RS:0], flit[W-1:W-RS]};
    end
  endgenerate

  // Pattern generator: first flit of a packet and successor of the current flit.
  // The flit register itself is the pattern state, so rotate/LFSR advance incrementally.
  always_comb begin
    mode_sel   = (state == S_IDLE) ? mode : mode_r;
    flit_first = '0;
    flit_step  = '0;
    case (mode_sel)
      2'd1: begin
        flit_first = SEED_EFF;
        flit_step  = (flit >> 1) ^ (flit[0] ? TAPS : '0);
      end
      2'd2: begin
        flit_first = ROT_BASE;
        flit_step  = flit_rot;
      end
      2'd3: begin
        flit_first = '1;
        flit_step  = ~flit;
      end
      default: begin
        flit_first = '0;
        flit_step  = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // FSM next state and flit load strobes; state reflects what is on the outputs this cycle.
  always_comb begin
    state_n    = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_SEND;
          load_first = 1'b1;
        end
      end
      S_SEND: begin
        if (last_flit) begin
          if (pkt_cnt + 16'd1 == 16'(NUM_PKT)) begin
            state_n = S_DONE;
          end else if (GAP == 0) begin
            state_n    = S_SEND;
            load_first = 1'b1;
          end else begin
            state_n = S_GAP;
          end
        end else begin
          load_next = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == G_W'(GAP - 1)) begin
          state_n    = S_SEND;
          load_first = 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Flit register, flit/gap indices, latched mode and packet counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit    <= '0;
      k       <= '0;
      gap_cnt <= '0;
      mode_r  <= '0;
      pkt_cnt <= '0;
    end else begin
      if (accept) begin
        mode_r  <= mode;
        pkt_cnt <= '0;
      end else if (state == S_SEND && last_flit) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (load_first) begin
        flit <= flit_first;
        k    <= '0;
      end else if (load_next) begin
        flit <= flit_step;
        k    <= k + 1'b1;
      end
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
    end
  end

  assign input1     = flit[N-1:0];
  assign input2     = flit[W-1:N];
  assign flit_valid = (state == S_SEND);
  assign busy       = (state == S_SEND) || (state == S_GAP);
  assign done       = (state == S_DONE);

  // Registered adder under test; sum_valid follows flit_valid by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      {cout, sum} <= {1'b0, input1} + {1'b0, input2};
      sum_valid   <= flit_valid;
    end
  end

`ifdef ADDER_CHAR_TOGGLE_CNT_EN
  logic [W-1:0]    flit_prev;
  logic [TCNT_W:0] tog_sum;

  function automatic logic [TCNT_W-1:0] popcount(input logic [W-1:0] v);
    logic [TCNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) c = c + TCNT_W'(v[i]);
    return c;
  endfunction

  always_comb tog_sum = {1'b0, toggle_cnt} + {1'b0, popcount(flit ^ flit_prev)};

  // Saturating count of operand bit flips between consecutive cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_prev  <= '0;
      toggle_cnt <= '0;
    end else begin
      flit_prev <= flit;
      if (accept)               toggle_cnt <= '0;
      else if (tog_sum[TCNT_W]) toggle_cnt <= '1;
      else                      toggle_cnt <= tog_sum[TCNT_W-1:0];
    end
  end
`else
  assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_char_injector.sv
// Directed bench for adder_char_injector: scoreboard of expected flits and sums,
// framing/done timing, reset behaviour and a single-flit configuration.
module tb_adder_char_injector;

  localparam int N   = 17;
  localparam int P   = 20;
  localparam int G   = 7;
  localparam int NP  = 10;
  localparam int END = NP * P + (NP - 1) * G;

  logic clk = 1'b0;
  logic rst, start, start2;
  logic [1:0] mode, mode2;

  logic [N-1:0] in1, in2, sum, in1_b, in2_b, sum_b;
  logic fv, cout, sv, busy, done, fv_b, cout_b, sv_b, busy_b, done_b;
  logic [15:0] pkt, pkt_b;
  logic [31:0] tog, tog_b;

  int total = 0;
  int bad   = 0;
  logic [33:0] q[$];
  logic [17:0] sq[$];

  always #5 clk = ~clk;

  adder_char_injector dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .input1(in1), .input2(in2), .flit_valid(fv), .sum(sum), .cout(cout),
    .sum_valid(sv), .busy(busy), .done(done), .pkt_cnt(pkt), .toggle_cnt(tog)
  );

  adder_char_injector #(.PAYLOAD(1), .GAP(0), .NUM_PKT(1)) dut_b (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2),
    .input1(in1_b), .input2(in2_b), .flit_valid(fv_b), .sum(sum_b), .cout(cout_b),
    .sum_valid(sv_b), .busy(busy_b), .done(done_b), .pkt_cnt(pkt_b), .toggle_cnt(tog_b)
  );

  // Reference flit k of a packet, computed directly from k.
  function automatic logic [33:0] model_flit(input int m, input int k);
    logic [33:0] f;
    case (m)
      0: f = '0;
      1: begin
        f = 34'h1;
        for (int i = 0; i < k; i++) f = (f >> 1) ^ (f[0] ? 34'h204000003 : 34'h0);
      end
      2: begin
        f = 34'h00000FFFFF;
        for (int i = 0; i < (k * 4) % 34; i++) f = {f[32:0], f[33]};
      end
      default: f = (k % 2 == 0) ? '1 : '0;
    endcase
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in1"}, in1, 0);
    chk({tag, "_in2"}, in2, 0);
    chk({tag, "_fv"}, fv, 0);
    chk({tag, "_sum"}, {cout, sum}, 0);
    chk({tag, "_sv"}, sv, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pkt"}, pkt, 0);
    chk({tag, "_tog"}, tog, 0);
  endtask

  // Full run on the default instance; called right after a negedge.
  task automatic run(input logic [1:0] m, input int tog_exp);
    logic [33:0] e;
    logic [17:0] es;
    logic        expv;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < P; k++) q.push_back(model_flit(int'(m), k));
    start = 1'b1;
    mode  = m;
    for (int c = 1; c <= END + 2; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      expv = (c <= END) && (((c - 1) % (P + G)) < P);
      chk("flit_valid", fv, expv);
      chk("busy", busy, c <= END);
      chk("done", done, c == END + 1);
      if (fv) begin
        if (q.size() != 0) e = q.pop_front();
        else e = 'x;
        chk("in1", in1, e[16:0]);
        chk("in2", in2, e[33:17]);
        sq.push_back({1'b0, e[16:0]} + {1'b0, e[33:17]});
      end
      if (sv) begin
        if (sq.size() != 0) es = sq.pop_front();
        else es = 'x;
        chk("sum", {cout, sum}, es);
      end
      if (c == P + 1 && tog_exp >= 0) chk("toggle_cnt", tog, tog_exp);
      if (m == 2'd2 && c == 1) begin
        chk("rot_in1", in1, 17'h1FFFF);
        chk("rot_in2", in2, 17'h00007);
      end
      if (m == 2'd2 && c == 2) chk("rot_sum", {cout, sum}, 18'h20006);
      if (m == 2'd1 && c == 1) begin
        chk("lfsr0_in1", in1, 17'h00001);
        chk("lfsr0_in2", in2, 17'h00000);
      end
      if (m == 2'd1 && c == 2) begin
        chk("lfsr1_in1", in1, 17'h00003);
        chk("lfsr1_in2", in2, 17'h10200);
      end
      if (m == 2'd1 && c == 3) chk("lfsr1_sum", {cout, sum}, 18'h10203);
      // start/mode disturbances while busy must not alter the run
      if (c == 30) begin
        start = 1'b1;
        mode  = m ^ 2'b01;
      end
      if (c == 31) start = 1'b0;
    end
    chk("pkt_cnt", pkt, NP);
    chk("q_left", q.size(), 0);
    chk("sq_left", sq.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; start2 = 1'b0; mode2 = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("por");

    // Abort mid-SEND with a 2-cycle reset
    start = 1'b1; mode = 2'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_fv", fv, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);

`ifdef ADDER_CHAR_TOGGLE_CNT_EN
    run(2'd3, 680);
`else
    run(2'd3, 0);
`endif
    run(2'd2, -1);
    run(2'd1, -1);
    run(2'd0, -1);

    // Single-flit configuration on the second instance
    start2 = 1'b1; mode2 = 2'd3;
    @(negedge clk);
    start2 = 1'b0;
    chk("b_fv1", fv_b, 1);
    chk("b_busy1", busy_b, 1);
    chk("b_done1", done_b, 0);
    chk("b_in1", in1_b, 17'h1FFFF);
    chk("b_in2", in2_b, 17'h1FFFF);
    @(negedge clk);
    chk("b_done2", done_b, 1);
    chk("b_busy2", busy_b, 0);
    chk("b_fv2", fv_b, 0);
    chk("b_sum", {cout_b, sum_b}, 18'h3FFFE);
    chk("b_sv", sv_b, 1);
    chk("b_pkt", pkt_b, 1);
    @(negedge clk);
    chk("b_done3", done_b, 0);
    chk("b_hold_in1", in1_b, 17'h1FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
